match_reporter: RTL and testbench

Downstream consumer of the 128-bit digest comparator in the MD5 search pipeline. Keeps a delay line of issued candidates aligned with the hash pipeline latency. On the first rising edge of the comparator's sticky match flag, it captures the candidate that produced the matching digest, raises `halt` to the candidate generator, and emits a framed byte stream to the host link over a valid/ready handshake.

---
 rtl/match_reporter.sv | 130 +++++++++++++
 tb/tb_match_reporter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/match_reporter.sv
// Captures the candidate behind the first comparator match and reports it as a framed byte stream.
// Latency: header valid one edge after cmp rises; backpressure: tx_valid/tx_data hold until tx_ready.
module match_reporter #(
    parameter int CAND_W  = 64,
    parameter int LATENCY = 65
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CAND_W-1:0] cand,
    input  logic              cand_valid,
    input  logic              cmp,
    output logic              found,
    output logic              halt,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);
    localparam int NB = CAND_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {IDLE, HDR, DATA, SUM, DONE} state_t;

    state_t            state;
    logic [CAND_W-1:0] dl_cand [LATENCY];
    logic              dl_val  [LATENCY];
    logic              cmp_q;
    logic              rise;
    logic              xfer;
    logic              cap_val;
    logic [CAND_W-1:0] cap_cand;
    logic [IW-1:0]     idx;
    logic [7:0]        chk;
    logic [7:0]        first_byte;
    logic [7:0]        nxt_byte;

    // Free-running: keeps alignment with the hash pipeline even after halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_cand[i] <= '0;
                dl_val[i]  <= 1'b0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                dl_cand[i] <= dl_cand[i-1];
                dl_val[i]  <= dl_val[i-1];
            end
            dl_cand[0] <= cand;
            dl_val[0]  <= cand_valid;
        end
    end

    assign rise       = cmp & ~cmp_q;
    assign xfer       = tx_valid & tx_ready;
    assign halt       = found;
    assign first_byte = cap_cand[CAND_W-1 -: 8];

    // Byte following the one currently on tx_data (idx+1), MSB first.
    always_comb begin
        nxt_byte = '0;
        for (int i = 0; i < NB - 1; i++) begin
            if (int'(idx) == i) begin
                nxt_byte = cap_cand[CAND_W-9-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cmp_q    <= 1'b0;
            found    <= 1'b0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            cap_val  <= 1'b0;
            cap_cand <= '0;
            idx      <= '0;
            chk      <= '0;
        end else begin
            cmp_q <= cmp;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cap_val  <= dl_val[LATENCY-1];
                        cap_cand <= dl_cand[LATENCY-1];
                        found    <= 1'b1;
                        busy     <= 1'b1;
                        idx      <= '0;
                        chk      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= dl_val[LATENCY-1] ? 8'hA5 : 8'hA6;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        tx_data <= first_byte;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        chk <= chk ^ tx_data;
                        idx <= idx + 1'b1;
                        if (idx == IW'(NB - 1)) begin
                            tx_data <= chk ^ tx_data;
                            state   <= SUM;
                        end else begin
                            tx_data <= nxt_byte;
                        end
                    end
                end
                SUM: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // One report per reset; later cmp activity is ignored.
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter (CAND_W=32, LATENCY=4) with a byte scoreboard.
module tb_match_reporter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cand;
    logic        cand_valid;
    logic        cmp;
    logic        found;
    logic        halt;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  st_b[$];
    int          st_c[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'h00;

    match_reporter #(.CAND_W(32), .LATENCY(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cand       (cand),
        .cand_valid (cand_valid),
        .cmp        (cmp),
        .found      (found),
        .halt       (halt),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic f, input logic b, input logic v);
        check({tag, "_found"}, {31'd0, found}, {31'd0, f});
        check({tag, "_halt"}, {31'd0, halt}, {31'd0, f});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, "_valid"}, {31'd0, tx_valid}, {31'd0, v});
    endtask

    task automatic push_frame(input logic v, input logic [31:0] c);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        exp_q.push_back(v ? 8'hA5 : 8'hA6);
        for (int i = 3; i >= 0; i--) begin
            b = c[8*i +: 8];
            exp_q.push_back(b);
            s = s ^ b;
        end
        exp_q.push_back(s);
    endtask

    // One clock: sample at negedge, choose tx_ready, score any transfer at the next edge.
    task automatic cycle();
        logic r;
        @(negedge clk);
        r = 1'b1;
        if (st_b.size() > 0 && tx_valid && tx_data == st_b[0]) begin
            if (st_c[0] > 0) begin
                r = 1'b0;
                st_c[0] = st_c[0] - 1;
            end else begin
                void'(st_b.pop_front());
                void'(st_c.pop_front());
            end
        end
        tx_ready = r;
        if (prev_stall) begin
            check("stall_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_data", {24'd0, tx_data}, {24'd0, prev_d});
        end
        if (!tx_valid) check("idle_data", {24'd0, tx_data}, 32'd0);
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("unexpected_byte", {31'd0, tx_valid}, 32'd0);
            else check("frame_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        prev_stall = tx_valid & ~tx_ready;
        prev_d     = tx_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cmp = 1'b0; cand_valid = 1'b0; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); st_b.delete(); st_c.delete();
        prev_stall = 1'b0;
    endtask

    // Candidate base+tap_i is sampled at edge e; cmp is first sampled high at e+4.
    task automatic capture_seq(input logic [31:0] base, input int tap_i, input logic tap_v);
        for (int i = 0; i <= tap_i + 4; i++) begin
            cycle();
            cand       = base + i;
            cand_valid = (i == tap_i) ? tap_v : 1'b1;
            cmp        = (i >= tap_i + 4);
        end
    endtask

    task automatic drain(input string tag, input int exp_cycles);
        int n;
        cycle();
        n = 1;
        check_outs({tag, "_hdr"}, 1'b1, 1'b1, 1'b1);
        while (exp_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        check({tag, "_frame_complete"}, exp_q.size(), 32'd0);
        check({tag, "_cycles"}, n, exp_cycles);
        cycle();
        check_outs({tag, "_after"}, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; cand = '0; cand_valid = 1'b0; cmp = 1'b0; tx_ready = 1'b0;

        // Reset held with random inputs, then released with cmp low.
        for (int i = 0; i < 6; i++) begin
            cycle();
            cand = $urandom; cand_valid = 1'($urandom_range(0, 1));
            cmp = 1'($urandom_range(0, 1)); tx_ready = 1'($urandom_range(0, 1));
        end
        cycle();
        check_outs("rst_held", 1'b0, 1'b0, 1'b0);
        check("rst_held_data", {24'd0, tx_data}, 32'd0);
        cmp = 1'b0; cand_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) cycle();
        check_outs("rst_released", 1'b0, 1'b0, 1'b0);
        check("rst_released_data", {24'd0, tx_data}, 32'd0);

        // Aligned capture, tx_ready always high.
        do_reset();
        push_frame(1'b1, 32'h12345678);
        capture_seq(32'h12345670, 8, 1'b1);
        drain("aligned", 6);

        // Backpressure on header (10 cycles) and on byte 0x34 (5 cycles).
        do_reset();
        st_b.push_back(8'hA5); st_c.push_back(10);
        st_b.push_back(8'h34); st_c.push_back(5);
        push_frame(1'b1, 32'h12345678);
        capture_seq(32'h12345670, 8, 1'b1);
        drain("backpressure", 21);

        // Invalid tap produces the 0xA6 header.
        do_reset();
        push_frame(1'b0, 32'hDEADBEEF);
        capture_seq(32'hDEADBEE7, 8, 1'b0);
        drain("invalid_tap", 6);

        // Reset pulsed while byte 0x56 is on the link.
        do_reset();
        push_frame(1'b1, 32'h12345678);
        capture_seq(32'h12345670, 8, 1'b1);
        repeat (3) cycle();
        @(negedge clk);
        tx_ready = 1'b0;
        check("midframe_pre_data", {24'd0, tx_data}, 32'h56);
        check("midframe_pre_valid", {31'd0, tx_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_outs("midframe_async", 1'b0, 1'b0, 1'b0);
        check("midframe_async_data", {24'd0, tx_data}, 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1; cmp = 1'b0; cand_valid = 1'b0; tx_ready = 1'b1;
        push_frame(1'b1, 32'h000000FF);
        capture_seq(32'h000000F7, 8, 1'b1);
        drain("after_reset", 6);

        // Further cmp rises after DONE are ignored.
        for (int k = 0; k < 3; k++) begin
            cycle(); cmp = 1'b0;
            cycle(); cmp = 1'b1;
            cycle(); cycle();
            check_outs("single_report", 1'b1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
